// File: rtl/ro_freq_meter.sv
`timescale 1ns/1ps
// Ring-oscillator frequency meter: counts ro_clk edges over a 2^gate_sel clk window through a Gray-coded crossing.
// Latency N+1 clk cycles from start to valid; no backpressure, start is ignored while busy.
module ro_freq_meter #(
    parameter int CNT_W       = 20,
    parameter int RES_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ro_clk,
    input  logic             start,
    input  logic [3:0]       gate_sel,
    output logic [RES_W-1:0] result,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, GATE, CALC} state_t;

    logic [SYNC_STAGES-1:0] ro_rst_q;
    logic [CNT_W-1:0]       ro_bin_q;
    logic [CNT_W-1:0]       ro_bin_d;
    logic [CNT_W-1:0]       ro_gray_q;

    assign ro_bin_d = ro_bin_q + CNT_W'(1);

    // Gray register is loaded from the next binary value so it tracks ro_bin_q edge for edge.
    always_ff @(posedge ro_clk) begin
        ro_rst_q <= {ro_rst_q[SYNC_STAGES-2:0], rst_n};
        if (!ro_rst_q[SYNC_STAGES-1]) begin
            ro_bin_q  <= '0;
            ro_gray_q <= '0;
        end else begin
            ro_bin_q  <= ro_bin_d;
            ro_gray_q <= ro_bin_d ^ (ro_bin_d >> 1);
        end
    end

    logic [CNT_W-1:0] gray_sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] snap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) gray_sync_q[i] <= '0;
        end else begin
            gray_sync_q[0] <= ro_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) gray_sync_q[i] <= gray_sync_q[i-1];
        end
    end

    always_comb begin
        snap = '0;
        for (int i = 0; i < CNT_W; i++) snap[i] = ^(gray_sync_q[SYNC_STAGES-1] >> i);
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] s0_q, s0_d, s1_q, s1_d, diff;
    logic [3:0]       n_lat_q, n_lat_d;
    logic [15:0]      timer_q, timer_d, gate_last;
    logic [RES_W-1:0] result_q, result_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;

    assign diff      = s1_q - s0_q;
    assign gate_last = (16'd1 << n_lat_q) - 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s0_q     <= '0;
            s1_q     <= '0;
            n_lat_q  <= 4'd4;
            timer_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            n_lat_q  <= n_lat_d;
            timer_q  <= timer_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        n_lat_d  = n_lat_q;
        timer_d  = timer_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    s0_d    = snap;
                    n_lat_d = (gate_sel < 4'd4) ? 4'd4 : gate_sel;
                    timer_d = '0;
                    state_d = GATE;
                end
            end
            GATE: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == gate_last) begin
                    s1_d    = snap;
                    state_d = CALC;
                end
            end
            CALC: begin
                valid_d = 1'b1;
                // Modulo subtraction above already absorbs counter wrap; saturate anything too wide.
                if ((diff >> RES_W) != '0) begin
                    result_d = '1;
                    ovf_d    = 1'b1;
                end else begin
                    result_d = diff[RES_W-1:0];
                    ovf_d    = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign result   = result_q;
    assign valid    = valid_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ro_freq_meter.sv
`timescale 1ns/1ps
// Bench for ro_freq_meter: directed and random gate/oscillator settings checked against an ideal edge-count model.
module tb_ro_freq_meter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ro_clk;
    logic        start;
    logic [3:0]  gate_sel;
    logic [15:0] result;
    logic        valid;
    logic        busy;
    logic        overflow;

    real ro_per = 40.0;
    int  checks = 0;
    int  errors = 0;

    ro_freq_meter #(.CNT_W(20), .RES_W(16), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ro_clk   (ro_clk),
        .start    (start),
        .gate_sel (gate_sel),
        .result   (result),
        .valid    (valid),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Oscillator is phase-shifted from clk; a period of 0 parks it low.
    initial begin
        ro_clk = 1'b0;
        #1.3;
        forever begin
            if (ro_per <= 0.0) begin
                ro_clk = 1'b0;
                #1;
            end else begin
                #(ro_per / 2.0);
                ro_clk = ~ro_clk;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs, input int lo, input int hi);
        checks++;
        assert (((int'(obs) >= lo) && (int'(obs) <= hi)) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic set_ro(input real per);
        ro_per = per;
        repeat (20) @(negedge clk);
    endtask

    // Ideal count is window length over oscillator period; allow one count of quantization each way.
    task automatic check_model(input string tag, input logic [3:0] g, input logic [15:0] res,
                               input logic ovf);
        int  n, lo, hi;
        real e;
        n  = 1 << ((g < 4'd4) ? 4 : int'(g));
        e  = (ro_per <= 0.0) ? 0.0 : (real'(n) * 10.0) / ro_per;
        lo = $rtoi(e) - 1;
        hi = $rtoi($ceil(e)) + 1;
        if (ro_per <= 0.0) begin
            chk({tag, "_res"}, 32'(res), 0);
            chk({tag, "_ovf"}, 32'(ovf), 0);
        end else if (lo >= 65536) begin
            chk({tag, "_res"}, 32'(res), 32'hFFFF);
            chk({tag, "_ovf"}, 32'(ovf), 1);
        end else if (hi < 65536) begin
            chk_rng({tag, "_res"}, 32'(res), lo, hi);
            chk({tag, "_ovf"}, 32'(ovf), 0);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] g, input int restart_at);
        int          n, lat, busy_cnt;
        logic [15:0] res;
        logic        ovf;
        n = 1 << ((g < 4'd4) ? 4 : int'(g));
        @(negedge clk);
        gate_sel = g;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        gate_sel = ~g;
        lat      = 0;
        busy_cnt = busy ? 1 : 0;
        while (!valid && lat < 40000) begin
            @(negedge clk);
            lat++;
            start = (lat == restart_at);
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        res   = result;
        ovf   = overflow;
        chk({tag, "_latency"}, 32'(lat), 32'(n + 1));
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
        check_model(tag, g, res, ovf);
        @(negedge clk);
        chk({tag, "_valid_pulse"}, 32'(valid), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        gate_sel = g;
    endtask

    initial begin
        int vcnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        gate_sel = 4'd0;
        repeat (20) @(negedge clk);
        chk("reset_result", 32'(result), 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        set_ro(40.0);
        run("basic", 4'd8, -1);
        set_ro(20.0);
        run("clamp", 4'd2, -1);
        run("long", 4'd12, -1);
        set_ro(4.8);
        run("ovf", 4'd15, -1);
        set_ro(5.0);
        run("ovf_clear", 4'd8, -1);
        set_ro(40.0);
        run("restart_ignored", 4'd8, 50);

        // Abort mid-gate: nothing may come out of the killed measurement.
        @(negedge clk);
        gate_sel = 4'd8;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_result", 32'(result), 0);
        chk("abort_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        vcnt  = 0;
        repeat (300) begin
            @(negedge clk);
            if (valid) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 0);
        chk("abort_result_hold", 32'(result), 0);

        run("after_abort", 4'd8, -1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_rst_result", 32'(result), 0);
        chk("idle_rst_valid", 32'(valid), 0);
        chk("idle_rst_busy", 32'(busy), 0);
        chk("idle_rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Park the oscillator counter just below its wrap point so the window straddles it.
        @(negedge ro_clk);
        force dut.ro_bin_q = 20'hFFFF6;
        #2;
        release dut.ro_bin_q;
        repeat (8) @(negedge clk);
        run("wrap", 4'd8, -1);

        set_ro(0.0);
        run("stopped", 4'd4, -1);

        for (int k = 0; k < 8; k++) begin
            set_ro(real'($urandom_range(6, 60)) + 0.37);
            run("rand", 4'($urandom_range(0, 11)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Measures the frequency of a free-running ring-oscillator clock (ro_clk) against the system clock clk.
- Sits directly downstream of the ring-oscillator counter stage: it takes the oscillator net as input and reports the count of oscillator edges seen in a programmable gate window.
- Counts in the ro_clk domain with a Gray-coded counter, crosses into the clk domain through synchronizers, and subtracts two snapshots.
- The result is exposed for pin readout and per-die oscillator characterisation.

Parameters:
- CNT_W, 20: width of the ro_clk-domain Gray counter (free-running, modulo 2^CNT_W).
- RES_W, 16: width of the reported result; must be less than or equal to CNT_W.
- SYNC_STAGES, 2: number of flops in each clock-domain-crossing synchronizer (minimum 2).

Ports:
- clk, input, 1: system clock; all control logic is in this domain.
- rst_n, input, 1: reset, synchronous, active-low.
- ro_clk, input, 1: ring-oscillator clock being measured; asynchronous to clk.
- start, input, 1: request a measurement; sampled on the clk rising edge.
- gate_sel, input, 4: gate window length N = 2^gate_sel clk cycles; values 0 to 3 are clamped to 4, so N is at least 16.
- result, output, RES_W: edge count from the last completed measurement.
- valid, output, 1: one-cycle pulse when result updates.
- busy, output, 1: high while a measurement is in progress.
- overflow, output, 1: the last measurement saturated.

Behaviour:
- ro domain reset:
  - rst_n passes through a SYNC_STAGES synchronizer clocked by ro_clk.
  - The synchronized low level resets the ro counter to 0, synchronous to ro_clk.
  - While rst_n is low and ro_clk is not toggling, the ro counter holds its value. The clk-domain logic tolerates any counter value.
- ro counter:
  - Binary counter, incremented on each ro_clk rising edge, wrapping at 2^CNT_W.
  - Registered Gray encoding: g = b ^ (b >> 1).
  - Only the Gray register crosses domains.
- Crossing: the Gray word passes through SYNC_STAGES clk flops, then is converted to binary (prefix XOR) combinationally in the clk domain. Call this value snap.
- Reset state (rst_n low at a clk edge): state=IDLE, result=0, valid=0, busy=0, overflow=0, timer=0, and all snapshot registers are 0.
- FSM states: IDLE, GATE, CALC.
  - IDLE: busy=0. If start=1 at edge E0:
    - s0 <= snap.
    - n_lat <= the clamped gate_sel.
    - timer <= 0.
    - Go to GATE.
  - GATE: busy=1; timer increments each cycle. At the edge where timer == 2^n_lat - 1 (edge E0+N):
    - s1 <= snap.
    - Go to CALC.
  - CALC: busy=1.
    - d = (s1 - s0) mod 2^CNT_W.
    - If d >= 2^RES_W: result <= all ones and overflow <= 1.
    - Otherwise: result <= d[RES_W-1:0] and overflow <= 0.
    - valid <= 1 for exactly this one update, seen in the cycle after edge E0+N+1.
    - Go to IDLE.
- Latency: valid rises N+1 clk cycles after the start edge.
- start while busy=1 is ignored, with no queueing.
- start held high re-arms on the cycle after CALC, giving back-to-back measurements with a 1-cycle IDLE gap.
- result and overflow hold their values until the next CALC or reset.
- gate_sel changes during GATE have no effect; n_lat is latched at start.
- Reset mid-GATE or mid-CALC:
  - Return to IDLE; result and overflow are cleared.
  - No valid pulse is issued for the aborted measurement.
- Accuracy:
  - ±1 count from synchronizer quantization (s0 and s1 see equal latency).
  - Valid only while ro_clk produces fewer than 2^CNT_W edges per window.
  - Gray coding guarantees any sampled value is either the old or the new count.
- ro_clk stopped: d=0, result=0, valid still pulses.

Test Plan:
- Reset: assert rst_n=0 for 3 clk cycles mid-idle -> result=0, valid=0, busy=0, overflow=0.
- Basic: clk period 10 ns, ro_clk period 40 ns, gate_sel=8, start pulse -> busy for 257 cycles; valid pulses once at start+257; result in the range 63..65.
- Clamp and long gate: gate_sel=2 with ro_clk=ck/2 -> N=16, result 7..9. Then gate_sel=12 -> N=4096, result 2047..2049.
- Overflow: ro_clk period 5 ns, clk 10 ns, gate_sel=15 -> d≈65536, so result=0xFFFF and overflow=1. Next run with gate_sel=8 -> overflow=0, result 511..513.
- Busy/abort: start pulsed again during GATE -> ignored, exactly one valid. Separate run: rst_n=0 at cycle 100 of GATE -> IDLE, no valid, result=0.
- Wrap and stopped clock:
  - Preload the ro counter near 2^20-10 (force), then measure 64 edges -> result 63..65, with correct modulo subtraction.
  - ro_clk held at 0 -> result=0 and valid pulses.
